// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : shared constants and helpers for the VGA raster timing generator.
//           Holds the 640x480@60 default timing (25.175 MHz pixel clock), the
//           coordinate width and the sync-window compare used by every axis.
// Ports   : none (package).
// Config  : VGA_TIMING_PREFETCH_EN (used by vga_timing_gen) enables the
//           prefetch coordinate outputs; DEF_PREFETCH is its default lead.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int COORD_W = 16;

   typedef logic [COORD_W-1:0] coord_t;

   // 640x480@60 defaults, horizontal in pixels, vertical in lines
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_PREFETCH = 2;

   // True when i_coord lies in [i_start, i_start + i_len). The end is formed
   // one bit wider so a window touching the top of the coordinate range
   // cannot wrap around.
   function automatic logic in_sync_window(input coord_t i_coord,
                                           input coord_t i_start,
                                           input coord_t i_len);
      logic [COORD_W:0] w_end;
      w_end = {1'b0, i_start} + {1'b0, i_len};
      return (i_coord >= i_start) && ({1'b0, i_coord} < w_end);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// Purpose : one raster axis (pixels of a line, or lines of a frame). Counts
//           0..TOTAL-1 on each advance strobe and registers the coordinate
//           together with its blank, sync and terminal flags, all decoded from
//           the next-state value so they describe the same position.
// Ports   : i_clk          clock, rising edge
//           i_rst_n        asynchronous active-low reset
//           i_advance      step the counter this clock
//           o_coord        registered coordinate
//           o_next_coord   value o_coord takes at the next edge (combinational,
//                          for registered decodes in the parent)
//           o_blank        registered, 1 when o_coord >= ACTIVE
//           o_sync         registered sync level, POL inside the sync window
//           o_wrap         registered, 1 when o_coord == TOTAL-1
// Notes   : reset forces the outputs to idle values (coord 0, blank 1, sync
//           inactive). The first edge after release loads START_VAL regardless
//           of i_advance; counting starts from there.
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   TOTAL      = 800,
   parameter int   ACTIVE     = 640,
   parameter int   SYNC_START = 656,
   parameter int   SYNC_LEN   = 96,
   parameter logic POL        = 1'b0,
   parameter int   START_VAL  = 0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_advance,
   output logic [COORD_W-1:0] o_coord,
   output logic [COORD_W-1:0] o_next_coord,
   output logic               o_blank,
   output logic               o_sync,
   output logic               o_wrap
);

   localparam coord_t C_LAST       = coord_t'(TOTAL - 1);
   localparam coord_t C_ACTIVE     = coord_t'(ACTIVE);
   localparam coord_t C_SYNC_START = coord_t'(SYNC_START);
   localparam coord_t C_SYNC_LEN   = coord_t'(SYNC_LEN);
   localparam coord_t C_START      = coord_t'(START_VAL);

   coord_t r_coord;
   logic   r_started;
   logic   r_blank;
   logic   r_sync;
   logic   r_wrap;
   coord_t w_next;

   // Until the first edge after reset the counter has not presented any
   // position yet, so that edge loads START_VAL instead of incrementing.
   always_comb begin
      w_next = r_coord;
      if (!r_started) begin
         w_next = C_START;
      end else if (i_advance) begin
         w_next = (r_coord == C_LAST) ? '0 : r_coord + coord_t'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_coord   <= '0;
         r_started <= 1'b0;
         r_blank   <= 1'b1;
         r_sync    <= ~POL;
         r_wrap    <= 1'b0;
      end else begin
         r_coord   <= w_next;
         r_started <= 1'b1;
         r_blank   <= (w_next >= C_ACTIVE);
         r_sync    <= in_sync_window(w_next, C_SYNC_START, C_SYNC_LEN) ? POL : ~POL;
         r_wrap    <= (w_next == C_LAST);
      end
   end

   assign o_coord      = r_coord;
   assign o_next_coord = w_next;
   assign o_blank      = r_blank;
   assign o_sync       = r_sync;
   assign o_wrap       = r_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Purpose : VGA raster timing generator feeding the text-screen tile layer.
//           Produces pixel coordinates, blanking, active-area, sync and
//           line/frame start strobes, all registered so they change together
//           and describe the same pixel.
// Ports   : i_pix_clk         pixel clock, rising edge
//           i_rst_n           asynchronous active-low reset
//           o_horz_coord      pixel column 0..H_TOTAL-1 (16 bit)
//           o_vert_coord      line 0..V_TOTAL-1 (16 bit)
//           o_horz_blank      1 when column >= H_ACTIVE
//           o_vert_blank      1 when line >= V_ACTIVE
//           o_in_active_area  1 inside the visible area
//           o_hsync/o_vsync   sync pulses, level HSYNC_POL/VSYNC_POL when asserted
//           o_line_start      1 on column 0
//           o_frame_start     1 on pixel (0,0)
//           o_fetch_horz/vert position PREFETCH clocks ahead (prefetch build only)
// Config  : define VGA_TIMING_PREFETCH_EN to add the fetch coordinate outputs,
//           generated by a second counter pair started PREFETCH pixels ahead.
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FRONT   = DEF_H_FRONT,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BACK    = DEF_H_BACK,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FRONT   = DEF_V_FRONT,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BACK    = DEF_V_BACK,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   PREFETCH  = DEF_PREFETCH
) (
   input  logic               i_pix_clk,
   input  logic               i_rst_n,
   output logic [COORD_W-1:0] o_horz_coord,
   output logic [COORD_W-1:0] o_vert_coord,
   output logic               o_horz_blank,
   output logic               o_vert_blank,
   output logic               o_in_active_area,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_line_start,
   output logic               o_frame_start
`ifdef VGA_TIMING_PREFETCH_EN
   ,
   output logic [COORD_W-1:0] o_fetch_horz,
   output logic [COORD_W-1:0] o_fetch_vert
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int COORD_RANGE = 2 ** COORD_W;

   localparam coord_t C_H_ACTIVE = coord_t'(H_ACTIVE);
   localparam coord_t C_V_ACTIVE = coord_t'(V_ACTIVE);

   // Elaboration-time sanity checks on the timing parameters.
   generate
      if (H_TOTAL > COORD_RANGE || V_TOTAL > COORD_RANGE) begin : g_bad_total
         $error("vga_timing_gen: line or frame total does not fit in %0d bits", COORD_W);
      end
      if (PREFETCH < 1 || PREFETCH > H_TOTAL - 1) begin : g_bad_prefetch
         $error("vga_timing_gen: PREFETCH must be in 1..H_TOTAL-1");
      end
   endgenerate

   coord_t w_h_coord;
   coord_t w_h_next;
   logic   w_h_blank;
   logic   w_h_sync;
   logic   w_h_wrap;
   coord_t w_v_coord;
   coord_t w_v_next;
   logic   w_v_blank;
   logic   w_v_sync;
   logic   w_unused_v_wrap;

   logic   r_in_active;
   logic   r_line_start;
   logic   r_frame_start;

   // Pixel axis: steps every clock.
   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FRONT),
      .SYNC_LEN   (H_SYNC),
      .POL        (HSYNC_POL),
      .START_VAL  (0)
   ) u_h_cnt (
      .i_clk        (i_pix_clk),
      .i_rst_n      (i_rst_n),
      .i_advance    (1'b1),
      .o_coord      (w_h_coord),
      .o_next_coord (w_h_next),
      .o_blank      (w_h_blank),
      .o_sync       (w_h_sync),
      .o_wrap       (w_h_wrap)
   );

   // Line axis: steps on the edge where the pixel axis leaves its last column,
   // so both axes roll over on the same edge at the end of the frame.
   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FRONT),
      .SYNC_LEN   (V_SYNC),
      .POL        (VSYNC_POL),
      .START_VAL  (0)
   ) u_v_cnt (
      .i_clk        (i_pix_clk),
      .i_rst_n      (i_rst_n),
      .i_advance    (w_h_wrap),
      .o_coord      (w_v_coord),
      .o_next_coord (w_v_next),
      .o_blank      (w_v_blank),
      .o_sync       (w_v_sync),
      .o_wrap       (w_unused_v_wrap)
   );

   // Combined flags are decoded from the next coordinates so they land in the
   // same cycle as the coordinates they describe.
   always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_in_active   <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_in_active   <= (w_h_next < C_H_ACTIVE) && (w_v_next < C_V_ACTIVE);
         r_line_start  <= (w_h_next == '0);
         r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
      end
   end

   assign o_horz_coord     = w_h_coord;
   assign o_vert_coord     = w_v_coord;
   assign o_horz_blank     = w_h_blank;
   assign o_vert_blank     = w_v_blank;
   assign o_hsync          = w_h_sync;
   assign o_vsync          = w_v_sync;
   assign o_in_active_area = r_in_active;
   assign o_line_start     = r_line_start;
   assign o_frame_start    = r_frame_start;

`ifdef VGA_TIMING_PREFETCH_EN
   // Second counter pair started PREFETCH pixels ahead of the main pair.
   // Because it runs on the same rules, its lead carries across line and
   // frame ends without any delay line.
   logic   w_fh_wrap;
   coord_t w_unused_fh_next;
   coord_t w_unused_fv_next;
   logic   w_unused_fh_blank;
   logic   w_unused_fv_blank;
   logic   w_unused_fh_sync;
   logic   w_unused_fv_sync;
   logic   w_unused_fv_wrap;

   vga_axis_counter #(
      .TOTAL      (H_TOTAL),
      .ACTIVE     (H_ACTIVE),
      .SYNC_START (H_ACTIVE + H_FRONT),
      .SYNC_LEN   (H_SYNC),
      .POL        (HSYNC_POL),
      .START_VAL  (PREFETCH)
   ) u_fh_cnt (
      .i_clk        (i_pix_clk),
      .i_rst_n      (i_rst_n),
      .i_advance    (1'b1),
      .o_coord      (o_fetch_horz),
      .o_next_coord (w_unused_fh_next),
      .o_blank      (w_unused_fh_blank),
      .o_sync       (w_unused_fh_sync),
      .o_wrap       (w_fh_wrap)
   );

   vga_axis_counter #(
      .TOTAL      (V_TOTAL),
      .ACTIVE     (V_ACTIVE),
      .SYNC_START (V_ACTIVE + V_FRONT),
      .SYNC_LEN   (V_SYNC),
      .POL        (VSYNC_POL),
      .START_VAL  (0)
   ) u_fv_cnt (
      .i_clk        (i_pix_clk),
      .i_rst_n      (i_rst_n),
      .i_advance    (w_fh_wrap),
      .o_coord      (o_fetch_vert),
      .o_next_coord (w_unused_fv_next),
      .o_blank      (w_unused_fv_blank),
      .o_sync       (w_unused_fv_sync),
      .o_wrap       (w_unused_fv_wrap)
   );
`endif

endmodule
